// File: rtl/student_computer.sv
`default_nettype none
// ============================================================================
//  Module   : student_computer
//  Purpose  : Single-cycle Hack computer. It contains the CPU, a 32K-word
//             instruction ROM taken from program_i, and a 32K-word data RAM.
//             The data RAM is preloaded from 'memory' while reset is low.
//  Ports    : clk          - system clock; all state updates on rising edge
//             reset        - asynchronous, active-low reset
//             program_i    - ROM image, word i = program_i[16*i +: 16]
//             memory       - RAM preload image, word i = memory[16*i +: 16]
//             ARegister    - A register
//             DRegister    - D register
//             pc           - program counter (15 bit, wraps)
//             mem_contents - live RAM image, word i = mem_contents[16*i +: 16]
//  Revision : 1.0 - initial release
// ============================================================================
// The ROM port cannot be called "program" because that name is a reserved
// SystemVerilog keyword.
module student_computer (
  input  logic            clk,
  input  logic            reset,
  input  logic [524287:0] program_i,
  input  logic [524287:0] memory,
  output logic [15:0]     ARegister,
  output logic [15:0]     DRegister,
  output logic [14:0]     pc,
  output logic [524287:0] mem_contents
);

  logic [15:0]     a_q, a_d;
  logic [15:0]     d_q, d_d;
  logic [14:0]     pc_q, pc_d;
  logic [524287:0] ram_q;

  logic [15:0] w_instr;
  logic [15:0] w_m_rd;
  logic [15:0] w_x;
  logic [15:0] w_y;
  logic [15:0] w_alu;
  logic        w_zr;
  logic        w_ng;
  logic        w_jump;
  logic        w_wr_m;
  logic [18:0] w_rom_bit;
  logic [18:0] w_ram_bit;

  // Bit offsets of the addressed 16-bit words inside the flat images.
  assign w_rom_bit = {pc_q, 4'b0000};
  assign w_ram_bit = {a_q[14:0], 4'b0000};

  assign w_instr = program_i[w_rom_bit +: 16];
  assign w_m_rd  = ram_q[w_ram_bit +: 16];

  // Hack ALU.  x is always D.  y is either A or M, depending on the 'a' bit.
  always_comb begin
    w_x = d_q;
    if (w_instr[11]) w_x = 16'h0000;
    if (w_instr[10]) w_x = ~w_x;

    w_y = w_instr[12] ? w_m_rd : a_q;
    if (w_instr[9]) w_y = 16'h0000;
    if (w_instr[8]) w_y = ~w_y;

    w_alu = w_instr[7] ? (w_x + w_y) : (w_x & w_y);
    if (w_instr[6]) w_alu = ~w_alu;

    w_zr = (w_alu == 16'h0000);
    w_ng = w_alu[15];
  end

  assign w_jump = (w_instr[2] & w_ng) | (w_instr[1] & w_zr) |
                  (w_instr[0] & ~w_ng & ~w_zr);

  // Next-state logic.  Every destination, and the jump target, is computed
  // from the values that the registers hold before the clock edge.
  always_comb begin
    a_d    = a_q;
    d_d    = d_q;
    pc_d   = pc_q + 15'd1;
    w_wr_m = 1'b0;
    if (!w_instr[15]) begin
      a_d = {1'b0, w_instr[14:0]};
    end else begin
      if (w_instr[5]) a_d = w_alu;
      if (w_instr[4]) d_d = w_alu;
      w_wr_m = w_instr[3];
      if (w_jump) pc_d = a_q[14:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q  <= 16'h0000;
      d_q  <= 16'h0000;
      pc_q <= 15'd0;
    end else begin
      a_q  <= a_d;
      d_q  <= d_d;
      pc_q <= pc_d;
    end
  end

  // While reset is low, the RAM copies the preload image. It does this on the
  // reset edge and again on every clock, so the RAM holds the latest image
  // when reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_q <= memory;
    end else if (w_wr_m) begin
      ram_q[w_ram_bit +: 16] <= w_alu;
    end
  end

  assign ARegister = a_q;
  assign DRegister = d_q;
  assign pc        = pc_q;
  // During reset the visible image follows 'memory' at once, with no wait
  // for a clock edge.
  assign mem_contents = reset ? ram_q : memory;

endmodule
`default_nettype wire

// File: tb/tb_student_computer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_student_computer
//  Purpose  : Self-checking bench for student_computer. It compares the DUT
//             against a behavioural Hack emulator that runs directed programs,
//             random programs and the rect program.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_student_computer;

  logic            clk = 1'b0;
  logic            reset;
  logic [524287:0] prog;
  logic [524287:0] mem;
  logic [15:0]     a_out;
  logic [15:0]     d_out;
  logic [14:0]     pc_out;
  logic [524287:0] mem_out;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [15:0] mrom [32768];
  logic [15:0] mpre [32768];
  logic [15:0] mram [32768];
  logic [15:0] ma, md;
  logic [14:0] mpc;
  int          last_wr;

  always #5 clk = ~clk;

  student_computer dut (
    .clk          (clk),
    .reset        (reset),
    .program_i    (prog),
    .memory       (mem),
    .ARegister    (a_out),
    .DRegister    (d_out),
    .pc           (pc_out),
    .mem_contents (mem_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] memw(input int i);
    return mem_out[16*i +: 16];
  endfunction

  task automatic load_images();
    for (int i = 0; i < 32768; i++) begin
      prog[16*i +: 16] = mrom[i];
      mem[16*i +: 16]  = mpre[i];
    end
  endtask

  task automatic clear_images();
    for (int i = 0; i < 32768; i++) begin
      mrom[i] = 16'h0000;
      mpre[i] = 16'h0000;
    end
  endtask

  task automatic model_reset();
    ma = 16'h0000;
    md = 16'h0000;
    mpc = 15'd0;
    last_wr = -1;
    for (int i = 0; i < 32768; i++) mram[i] = mpre[i];
  endtask

  // This models one instruction of the Hack architecture.
  task automatic model_step();
    logic [15:0] ins, x, y, o, old_a;
    logic signed [15:0] so;
    bit jmp;
    ins = mrom[mpc];
    last_wr = -1;
    if (ins[15] == 1'b0) begin
      ma  = {1'b0, ins[14:0]};
      mpc = mpc + 15'd1;
    end else begin
      old_a = ma;
      x = md;
      y = ins[12] ? mram[old_a[14:0]] : old_a;
      if (ins[11]) x = 16'h0000;
      if (ins[10]) x = ~x;
      if (ins[9])  y = 16'h0000;
      if (ins[8])  y = ~y;
      o = ins[7] ? 16'(x + y) : (x & y);
      if (ins[6]) o = ~o;
      so = o;
      jmp = (ins[2] && so < 0) || (ins[1] && so == 0) || (ins[0] && so > 0);
      if (ins[3]) begin
        mram[old_a[14:0]] = o;
        last_wr = int'(old_a[14:0]);
      end
      if (ins[5]) ma = o;
      if (ins[4]) md = o;
      mpc = jmp ? old_a[14:0] : mpc + 15'd1;
    end
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, "_A"},  a_out,  ma);
    check({tag, "_D"},  d_out,  md);
    check({tag, "_pc"}, pc_out, mpc);
    if (last_wr >= 0) check({tag, "_M"}, memw(last_wr), mram[last_wr]);
  endtask

  task automatic release_reset();
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic check_full_ram(input string tag);
    int nmis;
    nmis = 0;
    for (int i = 0; i < 32768; i++) if (memw(i) !== mram[i]) nmis++;
    check(tag, nmis, 0);
  endtask

  initial begin
    reset = 1'b0;
    prog  = '0;
    mem   = '0;

    // Reset state
    clear_images();
    mpre[0] = 16'd4;
    load_images();
    #2;
    check("rst_A",    a_out,  0);
    check("rst_D",    d_out,  0);
    check("rst_pc",   pc_out, 0);
    check("rst_mem0", memw(0), 16'd4);
    mem[15:0] = 16'd9;
    #1;
    check("rst_track", memw(0), 16'd9);
    mem[15:0] = 16'd4;
    #1;

    // Program A: @7; D=A; @2; D=A; @0; M=D; D=M
    mrom[0] = 16'h0007; mrom[1] = 16'hEC10;
    mrom[2] = 16'h0002; mrom[3] = 16'hEC10;
    mrom[4] = 16'h0000; mrom[5] = 16'hE308;
    mrom[6] = 16'hFC10;
    load_images();
    release_reset();
    step("a0");
    step("a1");
    check("t2_A",  a_out,  16'd7);
    check("t2_D",  d_out,  16'd7);
    check("t2_pc", pc_out, 15'd2);
    for (int i = 0; i < 4; i++) step("a_run");
    check("t3_ram0", memw(0), 16'd2);
    check("t3_pc",   pc_out,  15'd6);
    step("a6");
    check("t3_D",    d_out,   16'd2);

    // Program B: decrement, an unconditional jump, then one jump taken and
    // one jump not taken
    reset = 1'b0;
    clear_images();
    mpre[0] = 16'd4;
    mrom[0]  = 16'h0000; mrom[1]  = 16'hFC10; mrom[2]  = 16'hE390;
    mrom[3]  = 16'h000A; mrom[4]  = 16'hEA87;
    mrom[10] = 16'hEA90; mrom[11] = 16'h0014; mrom[12] = 16'hE301;
    mrom[13] = 16'hEE90; mrom[14] = 16'h001E; mrom[15] = 16'hE304;
    load_images();
    release_reset();
    for (int i = 0; i < 3; i++) step("b_dec");
    check("t4_D", d_out, 16'd3);
    step("b3");
    step("b4");
    check("t4_jmp", pc_out, 15'd10);
    for (int i = 0; i < 3; i++) step("b_jgt");
    check("t5_jgt_nt", pc_out, 15'd13);
    for (int i = 0; i < 3; i++) step("b_jlt");
    check("t5_jlt_t", pc_out, 15'd30);

    // Random program and random RAM contents
    reset = 1'b0;
    for (int i = 0; i < 32768; i++) begin
      mrom[i] = 16'($urandom);
      mpre[i] = 16'($urandom);
    end
    load_images();
    release_reset();
    for (int i = 0; i < 1500; i++) step("rnd");
    check_full_ram("rnd_ram");

    // Assert reset in the middle of the run, away from any clock edge
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("mid_A",    a_out,  0);
    check("mid_D",    d_out,  0);
    check("mid_pc",   pc_out, 0);
    check("mid_mem0", memw(0), mpre[0]);
    model_reset();
    check_full_ram("mid_ram");
    repeat (2) @(posedge clk);
    release_reset();
    for (int i = 0; i < 800; i++) step("rnd2");
    check_full_ram("rnd2_ram");

    // Rect program
    reset = 1'b0;
    clear_images();
    mpre[0] = 16'd4;
    mrom[0]  = 16'h0000; mrom[1]  = 16'hFC10; mrom[2]  = 16'h0017;
    mrom[3]  = 16'hE306; mrom[4]  = 16'h0010; mrom[5]  = 16'hE308;
    mrom[6]  = 16'h4000; mrom[7]  = 16'hEC10; mrom[8]  = 16'h0011;
    mrom[9]  = 16'hE308; mrom[10] = 16'h0011; mrom[11] = 16'hFC20;
    mrom[12] = 16'hEE88; mrom[13] = 16'h0011; mrom[14] = 16'hFC10;
    mrom[15] = 16'h0020; mrom[16] = 16'hE090; mrom[17] = 16'h0011;
    mrom[18] = 16'hE308; mrom[19] = 16'h0010; mrom[20] = 16'hFC98;
    mrom[21] = 16'h000A; mrom[22] = 16'hE301; mrom[23] = 16'h0017;
    mrom[24] = 16'hEA87;
    load_images();
    release_reset();
    for (int i = 0; i < 63; i++) begin
      step("rect");
      check("rect_r0", memw(0), mram[0]);
      check("rect_r1", memw(1), mram[1]);
      check("rect_r2", memw(2), mram[2]);
    end
    check_full_ram("rect_ram");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
